// File: rtl/core_mem_arb.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : core_mem_arb                                                    |
// | Purpose  : Shares one memory bus between instruction fetch and data        |
// |            accesses, one transaction at a time, data-first with a burst    |
// |            limiter. Optional response timeout: CORE_ARB_TIMEOUT_EN.        |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module core_mem_arb #(
  parameter int unsigned D_BURST_MAX = 4,
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        arb_i_req_in,
  input  logic [31:0] arb_i_addr_in,
  output logic        arb_i_ack_out,
  output logic [31:0] arb_i_rdata_out,
  input  logic        arb_d_req_in,
  input  logic        arb_d_we_in,
  input  logic [3:0]  arb_d_be_in,
  input  logic [31:0] arb_d_addr_in,
  input  logic [31:0] arb_d_wdata_in,
  output logic        arb_d_ack_out,
  output logic [31:0] arb_d_rdata_out,
  output logic        bus_req_out,
  output logic        bus_we_out,
  output logic [3:0]  bus_be_out,
  output logic [31:0] bus_addr_out,
  output logic [31:0] bus_wdata_out,
  input  logic        bus_gnt_in,
  input  logic        bus_rvalid_in,
  input  logic [31:0] bus_rdata_in,
  output logic        arb_stall_dec_out,
  output logic        arb_stall_wb_out,
  output logic        arb_err_out
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2,
    ST_ACK  = 2'd3
  } state_t;

  localparam logic [3:0] c_burst_lim = 4'(D_BURST_MAX);

  state_t      state_q, state_d;
  logic        own_data_q, own_data_d;
  logic        we_q, we_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] i_rdata_q, i_rdata_d;
  logic [31:0] d_rdata_q, d_rdata_d;
  logic [3:0]  burst_cnt_q, burst_cnt_d;
  logic        pick_data;

`ifdef CORE_ARB_TIMEOUT_EN
  localparam logic [9:0] c_tmo_lim = 10'(TIMEOUT_CYC);
  logic [9:0] tmo_cnt_q, tmo_cnt_d;
  logic       err_q, err_d;
`endif

  always_comb begin
    state_d     = state_q;
    own_data_d  = own_data_q;
    we_d        = we_q;
    be_d        = be_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    i_rdata_d   = i_rdata_q;
    d_rdata_d   = d_rdata_q;
    burst_cnt_d = burst_cnt_q;
    // Data wins unless the fetch side has already waited out a full burst.
    pick_data   = arb_d_req_in && !(arb_i_req_in && (burst_cnt_q == c_burst_lim));
`ifdef CORE_ARB_TIMEOUT_EN
    tmo_cnt_d   = tmo_cnt_q;
    err_d       = 1'b0;
`endif

    case (state_q)
      ST_IDLE: begin
        if (!arb_i_req_in) begin
          burst_cnt_d = 4'd0;
        end
        if (arb_i_req_in || arb_d_req_in) begin
          state_d    = ST_REQ;
          own_data_d = pick_data;
          if (pick_data) begin
            we_d    = arb_d_we_in;
            be_d    = arb_d_be_in;
            addr_d  = arb_d_addr_in;
            wdata_d = arb_d_wdata_in;
            if (arb_i_req_in && (burst_cnt_q != 4'hF)) begin
              burst_cnt_d = burst_cnt_q + 4'd1;
            end
          end else begin
            we_d        = 1'b0;
            be_d        = 4'hF;
            addr_d      = arb_i_addr_in;
            wdata_d     = 32'h0;
            burst_cnt_d = 4'd0;
          end
        end
      end
      ST_REQ: begin
        if (bus_gnt_in) begin
          state_d = ST_RESP;
`ifdef CORE_ARB_TIMEOUT_EN
          tmo_cnt_d = 10'd0;
`endif
        end
      end
      ST_RESP: begin
`ifdef CORE_ARB_TIMEOUT_EN
        tmo_cnt_d = tmo_cnt_q + 10'd1;
`endif
        if (bus_rvalid_in) begin
          state_d = ST_ACK;
          if (own_data_q) d_rdata_d = bus_rdata_in;
          else            i_rdata_d = bus_rdata_in;
        end
`ifdef CORE_ARB_TIMEOUT_EN
        else if ((tmo_cnt_q + 10'd1) == c_tmo_lim) begin
          state_d = ST_ACK;
          err_d   = 1'b1;
          if (own_data_q) d_rdata_d = 32'h0;
          else            i_rdata_d = 32'h0;
        end
`endif
      end
      ST_ACK: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      own_data_q  <= 1'b0;
      we_q        <= 1'b0;
      be_q        <= 4'h0;
      addr_q      <= 32'h0;
      wdata_q     <= 32'h0;
      i_rdata_q   <= 32'h0;
      d_rdata_q   <= 32'h0;
      burst_cnt_q <= 4'd0;
    end else begin
      state_q     <= state_d;
      own_data_q  <= own_data_d;
      we_q        <= we_d;
      be_q        <= be_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      i_rdata_q   <= i_rdata_d;
      d_rdata_q   <= d_rdata_d;
      burst_cnt_q <= burst_cnt_d;
    end
  end

`ifdef CORE_ARB_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      tmo_cnt_q <= 10'd0;
      err_q     <= 1'b0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
      err_q     <= err_d;
    end
  end

  assign arb_err_out = err_q;
`else
  assign arb_err_out = 1'b0;
`endif

  // Bus attributes are only presented while requesting; zero elsewhere.
  assign bus_req_out       = (state_q == ST_REQ);
  assign bus_we_out        = bus_req_out & we_q;
  assign bus_be_out        = bus_req_out ? be_q    : 4'h0;
  assign bus_addr_out      = bus_req_out ? addr_q  : 32'h0;
  assign bus_wdata_out     = bus_req_out ? wdata_q : 32'h0;

  assign arb_i_ack_out     = (state_q == ST_ACK) & ~own_data_q;
  assign arb_d_ack_out     = (state_q == ST_ACK) &  own_data_q;
  assign arb_i_rdata_out   = i_rdata_q;
  assign arb_d_rdata_out   = d_rdata_q;

  assign arb_stall_dec_out = arb_i_req_in & ~arb_i_ack_out;
  assign arb_stall_wb_out  = arb_d_req_in & ~arb_d_ack_out;

endmodule
`default_nettype wire

// File: tb/tb_core_mem_arb.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_core_mem_arb                                                 |
// | Purpose  : Cycle-vector bench for core_mem_arb plus burst/timeout runs.    |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_core_mem_arb;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, i_req, d_req, d_we, gnt, rvalid;
  logic [31:0] i_addr, d_addr, d_wdata, rdata;
  logic [3:0]  d_be;

  logic        i_ack, d_ack, breq, bwe, sdec, swb, err;
  logic [31:0] i_rdata, d_rdata, baddr, bwdata;
  logic [3:0]  bbe;

  logic        b_i_ack, b_d_ack, b_breq, b_bwe, b_sdec, b_swb, b_err;
  logic [31:0] b_i_rdata, b_d_rdata, b_baddr, b_bwdata;
  logic [3:0]  b_bbe;

  core_mem_arb #(.D_BURST_MAX(4), .TIMEOUT_CYC(8)) u_dut (
    .clk(clk), .rst(rst),
    .arb_i_req_in(i_req), .arb_i_addr_in(i_addr), .arb_i_ack_out(i_ack), .arb_i_rdata_out(i_rdata),
    .arb_d_req_in(d_req), .arb_d_we_in(d_we), .arb_d_be_in(d_be), .arb_d_addr_in(d_addr),
    .arb_d_wdata_in(d_wdata), .arb_d_ack_out(d_ack), .arb_d_rdata_out(d_rdata),
    .bus_req_out(breq), .bus_we_out(bwe), .bus_be_out(bbe), .bus_addr_out(baddr),
    .bus_wdata_out(bwdata), .bus_gnt_in(gnt), .bus_rvalid_in(rvalid), .bus_rdata_in(rdata),
    .arb_stall_dec_out(sdec), .arb_stall_wb_out(swb), .arb_err_out(err)
  );

  core_mem_arb #(.D_BURST_MAX(2), .TIMEOUT_CYC(8)) u_dut2 (
    .clk(clk), .rst(rst),
    .arb_i_req_in(i_req), .arb_i_addr_in(i_addr), .arb_i_ack_out(b_i_ack), .arb_i_rdata_out(b_i_rdata),
    .arb_d_req_in(d_req), .arb_d_we_in(d_we), .arb_d_be_in(d_be), .arb_d_addr_in(d_addr),
    .arb_d_wdata_in(d_wdata), .arb_d_ack_out(b_d_ack), .arb_d_rdata_out(b_d_rdata),
    .bus_req_out(b_breq), .bus_we_out(b_bwe), .bus_be_out(b_bbe), .bus_addr_out(b_baddr),
    .bus_wdata_out(b_bwdata), .bus_gnt_in(gnt), .bus_rvalid_in(rvalid), .bus_rdata_in(rdata),
    .arb_stall_dec_out(b_sdec), .arb_stall_wb_out(b_swb), .arb_err_out(b_err)
  );

  typedef struct {
    logic        rst;
    logic        ireq;
    logic [31:0] iaddr;
    logic        dreq;
    logic        dwe;
    logic [3:0]  dbe;
    logic [31:0] daddr;
    logic [31:0] dwdata;
    logic        gnt;
    logic        rv;
    logic [31:0] rdata;
    logic        x_breq;
    logic        x_bwe;
    logic [3:0]  x_bbe;
    logic [31:0] x_baddr;
    logic [31:0] x_bwdata;
    logic        x_iack;
    logic        x_dack;
    logic [31:0] x_irdata;
    logic [31:0] x_drdata;
    logic        x_sdec;
    logic        x_swb;
    logic        x_err;
  } vec_t;

  vec_t vecs[$];
  int   total = 0;
  int   bad   = 0;

  task automatic apply(input vec_t v);
    rst = v.rst; i_req = v.ireq; i_addr = v.iaddr;
    d_req = v.dreq; d_we = v.dwe; d_be = v.dbe; d_addr = v.daddr; d_wdata = v.dwdata;
    gnt = v.gnt; rvalid = v.rv; rdata = v.rdata;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [138:0] act, want;
    logic [5:0]   pat2, pat4;
    int           n2, n4;
    logic         e;

    rst = 1'b1; i_req = 1'b0; i_addr = 32'h0; d_req = 1'b0; d_we = 1'b0; d_be = 4'h0;
    d_addr = 32'h0; d_wdata = 32'h0; gnt = 1'b0; rvalid = 1'b0; rdata = 32'h0;
    repeat (2) @(posedge clk);
    #1;

    // Single fetch, then store/fetch collision
    vecs.push_back('{1'b1, 1'b1,32'h100, 1'b0,1'b0,4'h0,32'h0,32'h0, 1'b0,1'b0,32'h0, 1'b0,1'b0,4'h0,32'h0,32'h0, 1'b0,1'b0,32'h0,32'h0, 1'b1,1'b0,1'b0});
    vecs.push_back('{1'b0, 1'b1,32'h100, 1'b0,1'b0,4'h0,32'h0,32'h0, 1'b0,1'b0,32'h0, 1'b0,1'b0,4'h0,32'h0,32'h0, 1'b0,1'b0,32'h0,32'h0, 1'b1,1'b0,1'b0});
    vecs.push_back('{1'b0, 1'b1,32'h100, 1'b0,1'b0,4'h0,32'h0,32'h0, 1'b1,1'b0,32'h0, 1'b1,1'b0,4'hF,32'h100,32'h0, 1'b0,1'b0,32'h0,32'h0, 1'b1,1'b0,1'b0});
    vecs.push_back('{1'b0, 1'b1,32'h100, 1'b0,1'b0,4'h0,32'h0,32'h0, 1'b0,1'b1,32'hDEADBEEF, 1'b0,1'b0,4'h0,32'h0,32'h0, 1'b0,1'b0,32'h0,32'h0, 1'b1,1'b0,1'b0});
    vecs.push_back('{1'b0, 1'b1,32'h100, 1'b0,1'b0,4'h0,32'h0,32'h0, 1'b0,1'b0,32'h0, 1'b0,1'b0,4'h0,32'h0,32'h0, 1'b1,1'b0,32'hDEADBEEF,32'h0, 1'b0,1'b0,1'b0});
    vecs.push_back('{1'b0, 1'b0,32'h0, 1'b0,1'b0,4'h0,32'h0,32'h0, 1'b0,1'b0,32'h0, 1'b0,1'b0,4'h0,32'h0,32'h0, 1'b0,1'b0,32'hDEADBEEF,32'h0, 1'b0,1'b0,1'b0});
    vecs.push_back('{1'b0, 1'b1,32'h104, 1'b1,1'b1,4'h3,32'h400,32'h1234, 1'b0,1'b0,32'h0, 1'b0,1'b0,4'h0,32'h0,32'h0, 1'b0,1'b0,32'hDEADBEEF,32'h0, 1'b1,1'b1,1'b0});
    vecs.push_back('{1'b0, 1'b1,32'h104, 1'b1,1'b1,4'h3,32'h400,32'h1234, 1'b1,1'b0,32'h0, 1'b1,1'b1,4'h3,32'h400,32'h1234, 1'b0,1'b0,32'hDEADBEEF,32'h0, 1'b1,1'b1,1'b0});
    vecs.push_back('{1'b0, 1'b1,32'h104, 1'b1,1'b1,4'h3,32'h400,32'h1234, 1'b0,1'b1,32'hAAAA5555, 1'b0,1'b0,4'h0,32'h0,32'h0, 1'b0,1'b0,32'hDEADBEEF,32'h0, 1'b1,1'b1,1'b0});
    vecs.push_back('{1'b0, 1'b1,32'h104, 1'b1,1'b1,4'h3,32'h400,32'h1234, 1'b0,1'b0,32'h0, 1'b0,1'b0,4'h0,32'h0,32'h0, 1'b0,1'b1,32'hDEADBEEF,32'hAAAA5555, 1'b1,1'b0,1'b0});
    vecs.push_back('{1'b0, 1'b1,32'h104, 1'b0,1'b0,4'h0,32'h0,32'h0, 1'b0,1'b0,32'h0, 1'b0,1'b0,4'h0,32'h0,32'h0, 1'b0,1'b0,32'hDEADBEEF,32'hAAAA5555, 1'b1,1'b0,1'b0});
    vecs.push_back('{1'b0, 1'b1,32'h104, 1'b0,1'b0,4'h0,32'h0,32'h0, 1'b1,1'b0,32'h0, 1'b1,1'b0,4'hF,32'h104,32'h0, 1'b0,1'b0,32'hDEADBEEF,32'hAAAA5555, 1'b1,1'b0,1'b0});
    vecs.push_back('{1'b0, 1'b1,32'h104, 1'b0,1'b0,4'h0,32'h0,32'h0, 1'b0,1'b1,32'h0BADF00D, 1'b0,1'b0,4'h0,32'h0,32'h0, 1'b0,1'b0,32'hDEADBEEF,32'hAAAA5555, 1'b1,1'b0,1'b0});
    vecs.push_back('{1'b0, 1'b1,32'h104, 1'b0,1'b0,4'h0,32'h0,32'h0, 1'b0,1'b0,32'h0, 1'b0,1'b0,4'h0,32'h0,32'h0, 1'b1,1'b0,32'h0BADF00D,32'hAAAA5555, 1'b0,1'b0,1'b0});
    vecs.push_back('{1'b0, 1'b0,32'h0, 1'b0,1'b0,4'h0,32'h0,32'h0, 1'b0,1'b0,32'h0, 1'b0,1'b0,4'h0,32'h0,32'h0, 1'b0,1'b0,32'h0BADF00D,32'hAAAA5555, 1'b0,1'b0,1'b0});
    // Load under bus back-pressure with a spurious rvalid while requesting
    vecs.push_back('{1'b0, 1'b0,32'h0, 1'b1,1'b0,4'hF,32'h500,32'h0, 1'b0,1'b0,32'h0, 1'b0,1'b0,4'h0,32'h0,32'h0, 1'b0,1'b0,32'h0BADF00D,32'hAAAA5555, 1'b0,1'b1,1'b0});
    vecs.push_back('{1'b0, 1'b0,32'h0, 1'b1,1'b0,4'hF,32'h500,32'h0, 1'b0,1'b0,32'h0, 1'b1,1'b0,4'hF,32'h500,32'h0, 1'b0,1'b0,32'h0BADF00D,32'hAAAA5555, 1'b0,1'b1,1'b0});
    vecs.push_back('{1'b0, 1'b0,32'h0, 1'b1,1'b0,4'hF,32'h500,32'h0, 1'b0,1'b1,32'hFFFFFFFF, 1'b1,1'b0,4'hF,32'h500,32'h0, 1'b0,1'b0,32'h0BADF00D,32'hAAAA5555, 1'b0,1'b1,1'b0});
    for (int k = 0; k < 3; k++)
      vecs.push_back('{1'b0, 1'b0,32'h0, 1'b1,1'b0,4'hF,32'h500,32'h0, 1'b0,1'b0,32'h0, 1'b1,1'b0,4'hF,32'h500,32'h0, 1'b0,1'b0,32'h0BADF00D,32'hAAAA5555, 1'b0,1'b1,1'b0});
    vecs.push_back('{1'b0, 1'b0,32'h0, 1'b1,1'b0,4'hF,32'h500,32'h0, 1'b1,1'b0,32'h0, 1'b1,1'b0,4'hF,32'h500,32'h0, 1'b0,1'b0,32'h0BADF00D,32'hAAAA5555, 1'b0,1'b1,1'b0});
    vecs.push_back('{1'b0, 1'b0,32'h0, 1'b1,1'b0,4'hF,32'h500,32'h0, 1'b0,1'b0,32'h0, 1'b0,1'b0,4'h0,32'h0,32'h0, 1'b0,1'b0,32'h0BADF00D,32'hAAAA5555, 1'b0,1'b1,1'b0});
    vecs.push_back('{1'b0, 1'b0,32'h0, 1'b1,1'b0,4'hF,32'h500,32'h0, 1'b0,1'b1,32'h5A5A0001, 1'b0,1'b0,4'h0,32'h0,32'h0, 1'b0,1'b0,32'h0BADF00D,32'hAAAA5555, 1'b0,1'b1,1'b0});
    vecs.push_back('{1'b0, 1'b0,32'h0, 1'b1,1'b0,4'hF,32'h500,32'h0, 1'b0,1'b0,32'h0, 1'b0,1'b0,4'h0,32'h0,32'h0, 1'b0,1'b1,32'h0BADF00D,32'h5A5A0001, 1'b0,1'b0,1'b0});
    vecs.push_back('{1'b0, 1'b0,32'h0, 1'b0,1'b0,4'h0,32'h0,32'h0, 1'b0,1'b0,32'h0, 1'b0,1'b0,4'h0,32'h0,32'h0, 1'b0,1'b0,32'h0BADF00D,32'h5A5A0001, 1'b0,1'b0,1'b0});
    // Reset while waiting for the response; late rvalid must be dropped
    vecs.push_back('{1'b0, 1'b1,32'h600, 1'b0,1'b0,4'h0,32'h0,32'h0, 1'b0,1'b0,32'h0, 1'b0,1'b0,4'h0,32'h0,32'h0, 1'b0,1'b0,32'h0BADF00D,32'h5A5A0001, 1'b1,1'b0,1'b0});
    vecs.push_back('{1'b0, 1'b1,32'h600, 1'b0,1'b0,4'h0,32'h0,32'h0, 1'b1,1'b0,32'h0, 1'b1,1'b0,4'hF,32'h600,32'h0, 1'b0,1'b0,32'h0BADF00D,32'h5A5A0001, 1'b1,1'b0,1'b0});
    vecs.push_back('{1'b0, 1'b1,32'h600, 1'b0,1'b0,4'h0,32'h0,32'h0, 1'b0,1'b0,32'h0, 1'b0,1'b0,4'h0,32'h0,32'h0, 1'b0,1'b0,32'h0BADF00D,32'h5A5A0001, 1'b1,1'b0,1'b0});
    vecs.push_back('{1'b1, 1'b1,32'h600, 1'b0,1'b0,4'h0,32'h0,32'h0, 1'b0,1'b0,32'h0, 1'b0,1'b0,4'h0,32'h0,32'h0, 1'b0,1'b0,32'h0BADF00D,32'h5A5A0001, 1'b1,1'b0,1'b0});
    vecs.push_back('{1'b0, 1'b1,32'h600, 1'b0,1'b0,4'h0,32'h0,32'h0, 1'b0,1'b1,32'h12345678, 1'b0,1'b0,4'h0,32'h0,32'h0, 1'b0,1'b0,32'h0,32'h0, 1'b1,1'b0,1'b0});
    vecs.push_back('{1'b0, 1'b1,32'h600, 1'b0,1'b0,4'h0,32'h0,32'h0, 1'b1,1'b0,32'h0, 1'b1,1'b0,4'hF,32'h600,32'h0, 1'b0,1'b0,32'h0,32'h0, 1'b1,1'b0,1'b0});
    vecs.push_back('{1'b0, 1'b1,32'h600, 1'b0,1'b0,4'h0,32'h0,32'h0, 1'b0,1'b1,32'h0000600D, 1'b0,1'b0,4'h0,32'h0,32'h0, 1'b0,1'b0,32'h0,32'h0, 1'b1,1'b0,1'b0});
    vecs.push_back('{1'b0, 1'b1,32'h600, 1'b0,1'b0,4'h0,32'h0,32'h0, 1'b0,1'b0,32'h0, 1'b0,1'b0,4'h0,32'h0,32'h0, 1'b1,1'b0,32'h0000600D,32'h0, 1'b0,1'b0,1'b0});
    vecs.push_back('{1'b0, 1'b0,32'h0, 1'b0,1'b0,4'h0,32'h0,32'h0, 1'b0,1'b0,32'h0, 1'b0,1'b0,4'h0,32'h0,32'h0, 1'b0,1'b0,32'h0000600D,32'h0, 1'b0,1'b0,1'b0});

    for (int i = 0; i < vecs.size(); i++) begin
      apply(vecs[i]);
      @(negedge clk);
      act  = {breq, bwe, bbe, baddr, bwdata, i_ack, d_ack, i_rdata, d_rdata, sdec, swb, err};
      want = {vecs[i].x_breq, vecs[i].x_bwe, vecs[i].x_bbe, vecs[i].x_baddr, vecs[i].x_bwdata,
              vecs[i].x_iack, vecs[i].x_dack, vecs[i].x_irdata, vecs[i].x_drdata,
              vecs[i].x_sdec, vecs[i].x_swb, vecs[i].x_err};
      total++;
      if (act !== want) begin
        bad++;
        $display("FAIL vec%0d {req,we,be,addr,wdata,iack,dack,irdata,drdata,sdec,swb,err} got=%h want=%h",
                 i, act, want);
      end
      @(posedge clk);
      #1;
    end

    // Both requesters held; bus always grants and responds immediately
    i_req = 1'b1; i_addr = 32'h200;
    d_req = 1'b1; d_we = 1'b0; d_be = 4'hF; d_addr = 32'h300; d_wdata = 32'h0;
    gnt = 1'b1; rvalid = 1'b1; rdata = 32'h11;
    n2 = 0; n4 = 0; pat2 = 6'h0; pat4 = 6'h0;
    for (int c = 0; c < 60 && (n2 < 6 || n4 < 6); c++) begin
      @(negedge clk);
      if (breq && n4 < 6) begin
        pat4 = {pat4[4:0], baddr == 32'h300};
        n4++;
      end
      if (b_breq && n2 < 6) begin
        pat2 = {pat2[4:0], b_baddr == 32'h300};
        n2++;
      end
      @(posedge clk);
      #1;
    end
    total++;
    if (n2 != 6 || pat2 !== 6'b110110) begin
      bad++;
      $display("FAIL burst2_order grants=%0d order=%b want 6 grants order=110110 (1=D)", n2, pat2);
    end
    total++;
    if (n4 != 6 || pat4 !== 6'b111101) begin
      bad++;
      $display("FAIL burst4_order grants=%0d order=%b want 6 grants order=111101 (1=D)", n4, pat4);
    end

    rst = 1'b1; i_req = 1'b0; d_req = 1'b0; gnt = 1'b0; rvalid = 1'b0; rdata = 32'h0;
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Response never arrives
    d_req = 1'b1; d_we = 1'b0; d_be = 4'hF; d_addr = 32'h700;
    @(posedge clk);
    #1;
    gnt = 1'b1;
    @(negedge clk);
    total++;
    if (breq !== 1'b1 || baddr !== 32'h700) begin
      bad++;
      $display("FAIL tmo_req got req=%b addr=%h want req=1 addr=00000700", breq, baddr);
    end
    @(posedge clk);
    #1;
    gnt = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
`ifdef CORE_ARB_TIMEOUT_EN
      e = (k == 9);
`else
      e = 1'b0;
`endif
      total++;
      if ({d_ack, err, swb} !== {e, e, ~e} || (e && d_rdata !== 32'h0)) begin
        bad++;
        $display("FAIL tmo_cyc%0d got dack=%b err=%b swb=%b rdata=%h want dack=%b err=%b swb=%b",
                 k, d_ack, err, swb, d_rdata, e, e, ~e);
      end
      @(posedge clk);
      #1;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
